// File: rtl/seg7_pattern_rx.sv
// Recovers digits from an active-low 7-segment bus once a pattern has held for STABLE_CYCLES.
// Define SEG7_RX_HEX_EN to also decode the hex letters 8..F; otherwise those patterns are errors.
module seg7_pattern_rx #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERRW          = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      leds,
  output logic [3:0]      bcd,
  output logic            bcd_valid,
  input  logic            bcd_ready,
  output logic            pattern_err,
  output logic [ERRW-1:0] err_count,
  output logic            overflow
);

  localparam int unsigned CNTW  = 8;
  localparam logic [6:0]  BLANK = 7'h7F;

  typedef enum logic {SETTLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [6:0]      leds_q, leds_d;
  logic [6:0]      last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [3:0]      bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic [ERRW-1:0] errc_q, errc_d;
  logic            ovf_q, ovf_d;

  logic            changed;
  logic            accept;
  logic            dec_digit;
  logic            dec_err;
  logic [3:0]      dec_val;

  assign leds_d  = leds;
  assign last_d  = leds_q;
  assign changed = (leds_q != last_q);

  // Pattern table; blank is neither a digit nor an error.
  always_comb begin
    dec_digit = 1'b1;
    dec_err   = 1'b0;
    dec_val   = 4'd0;
    case (leds_q)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
`ifdef SEG7_RX_HEX_EN
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
`endif
      BLANK: dec_digit = 1'b0;
      default: begin
        dec_digit = 1'b0;
        dec_err   = 1'b1;
      end
    endcase
  end

  // Stability tracking: accept fires on the edge where the count would reach STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (changed) begin
          cnt_d = CNTW'(1);
        end else if (cnt_q == CNTW'(STABLE_CYCLES - 1)) begin
          accept  = 1'b1;
          cnt_d   = CNTW'(STABLE_CYCLES);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      HOLD: begin
        if (changed) begin
          state_d = SETTLE;
          cnt_d   = CNTW'(1);
        end
      end
    endcase
  end

  // Error reporting and the 1-deep output buffer.
  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    perr_d  = 1'b0;
    errc_d  = errc_q;
    ovf_d   = ovf_q;
    if (accept && dec_err) begin
      perr_d = 1'b1;
      if (errc_q != '1) errc_d = errc_q + ERRW'(1);
    end
    if (accept && dec_digit) begin
      if (!valid_q || bcd_ready) begin
        bcd_d   = dec_val;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && bcd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SETTLE;
      leds_q  <= BLANK;
      last_q  <= BLANK;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      errc_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      errc_q  <= errc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd         = bcd_q;
  assign bcd_valid   = valid_q;
  assign pattern_err = perr_q;
  assign err_count   = errc_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// Directed bench for seg7_pattern_rx: digits are checked through a scoreboard queue at each handshake.
module tb_seg7_pattern_rx;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] leds;
  logic [3:0] bcd;
  logic       bcd_valid;
  logic       bcd_ready;
  logic       pattern_err;
  logic [7:0] err_count;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int err0;
  int q_exp[$];

`ifdef SEG7_RX_HEX_EN
  localparam int HEX = 1;
`else
  localparam int HEX = 0;
`endif

  seg7_pattern_rx #(.STABLE_CYCLES(S), .ERRW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .leds        (leds),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid),
    .bcd_ready   (bcd_ready),
    .pattern_err (pattern_err),
    .err_count   (err_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: score any handshake that the coming edge completes, then sample #1 after it.
  task automatic tick();
    if (bcd_valid && bcd_ready) begin
      chk("sb_digit_expected", int'(q_exp.size() > 0), 1);
      if (q_exp.size() > 0) chk("sb_bcd", int'(bcd), q_exp.pop_front());
    end
    if (pattern_err) err_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    leds = pat;
    repeat (n) tick();
  endtask

  initial begin
    reset     = 1'b1;
    leds      = 7'h7F;
    bcd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_valid", int'(bcd_valid), 0);
    chk("rst_perr", int'(pattern_err), 0);
    chk("rst_errcnt", int'(err_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    repeat (S + 3) tick();
    chk("blank_no_valid", int'(bcd_valid), 0);

    // Digit 2 with ready high: one-cycle valid, S edges after the change is sampled.
    bcd_ready = 1'b1;
    q_exp.push_back(2);
    hold(7'h24, S);
    chk("t1_pre_valid", int'(bcd_valid), 0);
    tick();
    chk("t1_valid", int'(bcd_valid), 1);
    chk("t1_bcd", int'(bcd), 2);
    tick();
    chk("t1_valid_drop", int'(bcd_valid), 0);
    repeat (3) tick();
    chk("t1_once", int'(bcd_valid), 0);

    // Short glitch on 1 followed by stable 3.
    err0 = err_seen;
    hold(7'h79, 2);
    q_exp.push_back(3);
    hold(7'h30, S + 3);
    chk("t2_sb_drained", q_exp.size(), 0);
    chk("t2_no_perr", err_seen - err0, 0);
    chk("t2_errcnt", int'(err_count), 0);

    // Pattern 00: error without hex decoding, digit 8 with it.
    err0 = err_seen;
    if (HEX != 0) q_exp.push_back(8);
    hold(7'h00, S + 1);
    chk("t3_perr", int'(pattern_err), 1 - HEX);
    chk("t3_valid", int'(bcd_valid), HEX);
    chk("t3_errcnt", int'(err_count), 1 - HEX);
    repeat (4) tick();
    chk("t3_perr_count", err_seen - err0, 1 - HEX);
    chk("t3_errcnt_hold", int'(err_count), 1 - HEX);
    chk("t3_sb_drained", q_exp.size(), 0);

    // Stalled consumer: 0 is held, 7 is dropped and overflow sticks.
    bcd_ready = 1'b0;
    q_exp.push_back(0);
    hold(7'h40, S + 2);
    chk("t4_valid0", int'(bcd_valid), 1);
    hold(7'h78, S + 2);
    chk("t4_bcd_held", int'(bcd), 0);
    chk("t4_valid_held", int'(bcd_valid), 1);
    chk("t4_ovf", int'(overflow), 1);
    bcd_ready = 1'b1;
    tick();
    chk("t4_valid_drop", int'(bcd_valid), 0);
    repeat (3) tick();
    chk("t4_no_seven", int'(bcd_valid), 0);
    chk("t4_ovf_sticky", int'(overflow), 1);
    chk("t4_sb_drained", q_exp.size(), 0);

    // Asynchronous reset in the middle of settling on 4.
    hold(7'h19, 2);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_bcd", int'(bcd), 0);
    chk("t5_rst_valid", int'(bcd_valid), 0);
    chk("t5_rst_perr", int'(pattern_err), 0);
    chk("t5_rst_errcnt", int'(err_count), 0);
    chk("t5_rst_ovf", int'(overflow), 0);
    repeat (2) tick();
    reset = 1'b0;
    q_exp.push_back(4);
    repeat (S) tick();
    chk("t5_pre_valid", int'(bcd_valid), 0);
    tick();
    chk("t5_valid", int'(bcd_valid), 1);
    chk("t5_bcd", int'(bcd), 4);
    tick();

    // Blank / 5 alternation: 5 reported twice, blanks silent.
    err0 = err_seen;
    hold(7'h7F, 5);
    q_exp.push_back(5);
    hold(7'h12, 5);
    hold(7'h7F, 5);
    q_exp.push_back(5);
    hold(7'h12, 5);
    repeat (3) tick();
    chk("t6_sb_drained", q_exp.size(), 0);
    chk("t6_no_perr", err_seen - err0, 0);
    chk("t6_errcnt", int'(err_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_rx.md
Name: seg7_pattern_rx

Overview:
- Reader end of the 7-segment display interface: watches an active-low 7-segment pattern bus and recovers the digit value it encodes.
- Requires each pattern to be stable for a programmable number of cycles, then decodes it once.
- Delivers the digit through a 1-deep valid/ready output buffer; flags unrecognised patterns.
- Used by display loopback checkers and by blocks that snoop digits driven onto the HEX displays.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles a registered pattern must hold before it is accepted (legal range 2..255).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- leds  in  7  active-low segment pattern; bit6=g … bit0=a.
- bcd  out  4  decoded digit; bit3 is 0 unless SEG7_RX_HEX_EN is defined.
- bcd_valid  out  1  bcd holds an undelivered digit.
- bcd_ready  in  1  consumer accepts bcd on a clock edge where bcd_valid=1.
- pattern_err  out  1  one-cycle pulse: a stable pattern was not a legal digit.
- err_count  out  ERRW  count of pattern_err pulses; saturates at all-ones.
- overflow  out  1  sticky: an accepted digit was dropped because the buffer was full.

Behaviour:
- Reset (async): bcd=0, bcd_valid=0, pattern_err=0, err_count=0, overflow=0. leds_q and last-pattern register = 7'h7F (blank). State=SETTLE, stability count=0.
- leds is registered once (leds_q) before all logic. No other synchronisation is provided; the source must be synchronous to clk.
- FSM has two states:
  - SETTLE: if leds_q ≠ leds_q from the previous cycle, count←1; else count increments. When count reaches STABLE_CYCLES, accept the pattern and go to HOLD.
  - HOLD: stay while leds_q is unchanged. Any change → SETTLE with count=1.
- Latency: leds changes before edge k and then holds → bcd_valid rises after edge k+STABLE_CYCLES.
- Decode table (active-low leds → value):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7.
  - 7F (blank) → no digit and no error.
  - Any other value → pattern_err pulse plus err_count increment (saturating).
- Each stable pattern is reported at most once. Re-applying the same value without an intervening change produces nothing.
- Output buffer:
  - Accept with buffer empty, or bcd_ready=1 on the same edge → load bcd and set bcd_valid.
  - Accept with bcd_valid=1 and bcd_ready=0 → new digit dropped, overflow←1, existing bcd unchanged.
  - bcd_valid=1 and bcd_ready=1 with no new accept → bcd_valid←0; bcd keeps its last value.
  - bcd must not change while bcd_valid=1 and bcd_ready=0.
- A glitch shorter than STABLE_CYCLES produces nothing: no digit, no error, no counter change.
- Reset mid-settle or mid-handshake discards all pending state. After release, the next digit needs a full STABLE_CYCLES.

Optional Feature:
- SEG7_RX_HEX_EN defined: the table extends to 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F, with bcd[3] set as appropriate. These patterns are then not errors.
- Not defined: those eight patterns raise pattern_err, and bcd[3] is tied to 0.

Test Plan:
- leds=24 for 6 cycles, bcd_ready=1 → bcd=2, bcd_valid high exactly one cycle, 4 edges after the change.
- leds=79 for 2 cycles, then 30 held → only bcd=3 reported; pattern_err never pulses.
- leds=00 held 5 cycles → no HEX_EN: pattern_err 1 pulse, err_count=1, no bcd_valid. With HEX_EN: bcd=8, err_count=0.
- bcd_ready=0; leds=40 stable, then 78 stable → bcd=0 valid and held, overflow=1. Raise bcd_ready → bcd_valid drops; 7 never appears.
- leds=19 for 2 cycles, assert reset asynchronously, release, hold 19 → all outputs 0 during reset; bcd=4 appears 4 edges after release.
- leds=7F held, then 7F→12→7F→12, each held 5 cycles → bcd=5 reported twice, no error on blanks.
